// File: rtl/branch_redirect_sequencer_pkg.sv
// Shared definitions for the branch redirect sequencer: kind codes, ExcCodes,
// default vectors and FSM/redirect-class encodings.
package branch_redirect_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;

  typedef enum logic [3:0] {
    K_JR      = 4'd0,
    K_J       = 4'd1,
    K_JAL     = 4'd2,
    K_BEQ     = 4'd3,
    K_BNE     = 4'd4,
    K_BGEZ    = 4'd5,
    K_JALR    = 4'd6,
    K_BREAK   = 4'd7,
    K_SYSCALL = 4'd8,
    K_ERET    = 4'd9,
    K_TEQ     = 4'd10
  } kind_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_TR   = 5'd13;

  typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_EXC} state_e;

  typedef enum logic [1:0] {CLS_NONE, CLS_BRANCH, CLS_ERET, CLS_TRAP} redir_cls_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_redirect_sequencer_target_calc.sv
// Combinational redirect target, redirect class and ExcCode for the ID instruction.
// ALIGN_CHECK_EN turns misaligned register/EPC targets into AdEL traps.
module redirect_target_calc
  import branch_redirect_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [3:0]  branch_ena,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] rs_data,
  input  logic [31:0] epc_data,
  output logic [31:0] target,
  output logic [1:0]  redir_cls,
  output logic [4:0]  exc_cause
);

  logic [31:0] pc_plus4;
  logic [31:0] raw_target;
  logic        check_align;
  redir_cls_e  cls;

  assign pc_plus4 = id_pc + 32'd4;

  always_comb begin
    raw_target  = pc_plus4;
    cls         = CLS_NONE;
    exc_cause   = '0;
    check_align = 1'b0;
    case (branch_ena)
      K_JR, K_JALR: begin
        raw_target  = rs_data;
        cls         = CLS_BRANCH;
        check_align = 1'b1;
      end
      K_J, K_JAL: begin
        raw_target = {pc_plus4[31:28], id_index26, 2'b00};
        cls        = CLS_BRANCH;
      end
      K_BEQ, K_BNE, K_BGEZ: begin
        raw_target = pc_plus4 + branch_offset(id_imm16);
        cls        = CLS_BRANCH;
      end
      K_BREAK: begin
        raw_target = EXC_VECTOR;
        cls        = CLS_TRAP;
        exc_cause  = EXC_BP;
      end
      K_SYSCALL: begin
        raw_target = EXC_VECTOR;
        cls        = CLS_TRAP;
        exc_cause  = EXC_SYS;
      end
      K_TEQ: begin
        raw_target = EXC_VECTOR;
        cls        = CLS_TRAP;
        exc_cause  = EXC_TR;
      end
      K_ERET: begin
        raw_target  = epc_data;
        cls         = CLS_ERET;
        check_align = 1'b1;
      end
      default: ;
    endcase
`ifdef ALIGN_CHECK_EN
    target = raw_target;
    if (check_align && (raw_target[1:0] != 2'b00)) begin
      target    = EXC_VECTOR;
      cls       = CLS_TRAP;
      exc_cause = EXC_ADEL;
    end
`else
    // Only register/EPC sourced targets can carry low bits; drop them silently.
    target = check_align ? {raw_target[31:2], 2'b00} : raw_target;
`endif
  end

  assign redir_cls = cls;

endmodule

// File: rtl/branch_redirect_sequencer.sv
// Fetch PC owner: applies ID redirects, parks redirects across IF stalls and
// sequences exception entry / ERET. Optional macro: ALIGN_CHECK_EN.
module branch_redirect_sequencer
  import branch_redirect_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        id_valid,
  input  logic        id_branch,
  input  logic [3:0]  branch_ena,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] rs_data,
  input  logic [31:0] epc_data,
  output logic [31:0] pc_out,
  output logic        if_flush,
  output logic        exc_req,
  output logic [4:0]  exc_cause,
  output logic [31:0] exc_epc,
  output logic        eret_ack
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_eret_q, pend_eret_d;
  logic        if_flush_q, if_flush_d;
  logic        exc_req_q, exc_req_d;
  logic [4:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_epc_q, exc_epc_d;
  logic        eret_ack_q, eret_ack_d;

  logic [31:0] calc_target;
  logic [1:0]  calc_cls;
  logic [4:0]  calc_cause;
  logic        redirect_ev;

  redirect_target_calc #(.EXC_VECTOR(EXC_VECTOR)) u_calc (
    .branch_ena (branch_ena),
    .id_pc      (id_pc),
    .id_imm16   (id_imm16),
    .id_index26 (id_index26),
    .rs_data    (rs_data),
    .epc_data   (epc_data),
    .target     (calc_target),
    .redir_cls  (calc_cls),
    .exc_cause  (calc_cause)
  );

  assign redirect_ev = id_valid & id_branch;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_eret_d   = pend_eret_q;
    if_flush_d    = 1'b0;
    exc_req_d     = 1'b0;
    exc_cause_d   = '0;
    exc_epc_d     = '0;
    eret_ack_d    = 1'b0;
    // A trap wins over everything except reset, but ID is being flushed during EXC.
    if (state_q != ST_EXC && redirect_ev && calc_cls == CLS_TRAP) begin
      state_d     = ST_EXC;
      pc_d        = calc_target;
      pend_eret_d = 1'b0;
      if_flush_d  = 1'b1;
      exc_req_d   = 1'b1;
      exc_cause_d = calc_cause;
      exc_epc_d   = id_pc;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (redirect_ev && calc_cls != CLS_NONE) begin
            if (if_stall) begin
              state_d       = ST_PEND;
              pend_target_d = calc_target;
              pend_eret_d   = (calc_cls == CLS_ERET);
            end else begin
              pc_d       = calc_target;
              if_flush_d = (calc_cls == CLS_ERET);
              eret_ack_d = (calc_cls == CLS_ERET);
            end
          end else if (!if_stall) begin
            pc_d = pc_q + 32'd4;
          end
        end
        ST_PEND: begin
          if (!if_stall) begin
            state_d    = ST_RUN;
            pc_d       = pend_target_q;
            if_flush_d = pend_eret_q;
            eret_ack_d = pend_eret_q;
          end
        end
        ST_EXC: begin
          state_d = ST_RUN;
          if (!if_stall) pc_d = pc_q + 32'd4;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      pend_eret_q   <= 1'b0;
      if_flush_q    <= 1'b0;
      exc_req_q     <= 1'b0;
      exc_cause_q   <= '0;
      exc_epc_q     <= '0;
      eret_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_eret_q   <= pend_eret_d;
      if_flush_q    <= if_flush_d;
      exc_req_q     <= exc_req_d;
      exc_cause_q   <= exc_cause_d;
      exc_epc_q     <= exc_epc_d;
      eret_ack_q    <= eret_ack_d;
    end
  end

  assign pc_out    = pc_q;
  assign if_flush  = if_flush_q;
  assign exc_req   = exc_req_q;
  assign exc_cause = exc_cause_q;
  assign exc_epc   = exc_epc_q;
  assign eret_ack  = eret_ack_q;

endmodule

// File: tb/tb_branch_redirect_sequencer.sv
// Scoreboard bench for branch_redirect_sequencer: directed scenarios then random
// cycles, each checked against a cycle-level behavioural model.
module tb_branch_redirect_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst, if_stall, id_valid, id_branch;
  logic [3:0]  branch_ena;
  logic [31:0] id_pc, rs_data, epc_data;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [31:0] pc_out, exc_epc;
  logic        if_flush, exc_req, eret_ack;
  logic [4:0]  exc_cause;

  always #5 clk = ~clk;

  branch_redirect_sequencer dut (
    .clk(clk), .rst(rst), .if_stall(if_stall), .id_valid(id_valid),
    .id_branch(id_branch), .branch_ena(branch_ena), .id_pc(id_pc),
    .id_imm16(id_imm16), .id_index26(id_index26), .rs_data(rs_data),
    .epc_data(epc_data), .pc_out(pc_out), .if_flush(if_flush),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_epc(exc_epc),
    .eret_ack(eret_ack)
  );

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        req;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        eret;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model state: fetch PC, one parked redirect, exception cycle flag.
  logic [31:0] m_pc;
  bit          m_pend, m_pend_eret, m_exc;
  logic [31:0] m_pend_tgt;

  // cls: 0 no redirect, 1 branch/jump, 2 ERET, 3 trap
  function automatic void ref_target(input logic [3:0] k, input logic [31:0] pc,
                                     input logic [15:0] imm, input logic [25:0] idx,
                                     input logic [31:0] rs, input logic [31:0] epc,
                                     output int cls, output logic [31:0] tgt,
                                     output logic [4:0] cause);
    int off;
    logic [31:0] v;
    cls = 0; tgt = 32'd0; cause = 5'd0; v = 32'd0;
    off = int'($signed(imm));
    case (k)
      4'd1, 4'd2: begin
        cls = 1;
        tgt = ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
      end
      4'd3, 4'd4, 4'd5: begin
        cls = 1;
        tgt = pc + 32'd4 + 32'(off * 4);
      end
      4'd7:  begin cls = 3; tgt = EXC_VEC; cause = 5'd9;  end
      4'd8:  begin cls = 3; tgt = EXC_VEC; cause = 5'd8;  end
      4'd10: begin cls = 3; tgt = EXC_VEC; cause = 5'd13; end
      4'd0, 4'd6, 4'd9: begin
        v = (k == 4'd9) ? epc : rs;
        cls = (k == 4'd9) ? 2 : 1;
        if (v % 4 != 0) begin
`ifdef ALIGN_CHECK_EN
          cls = 3; tgt = EXC_VEC; cause = 5'd4;
`else
          tgt = v - (v % 4);
`endif
        end else begin
          tgt = v;
        end
      end
      default: cls = 0;
    endcase
  endfunction

  task automatic step(input bit r, input bit st, input bit v, input bit b,
                      input logic [3:0] k, input logic [31:0] pc,
                      input logic [15:0] imm, input logic [25:0] idx,
                      input logic [31:0] rs, input logic [31:0] epc);
    exp_t e;
    int cls;
    logic [31:0] tgt;
    logic [4:0] cause;
    @(negedge clk);
    rst = r; if_stall = st; id_valid = v; id_branch = b; branch_ena = k;
    id_pc = pc; id_imm16 = imm; id_index26 = idx; rs_data = rs; epc_data = epc;
    e.flush = 1'b0; e.req = 1'b0; e.cause = 5'd0; e.epc = 32'd0; e.eret = 1'b0;
    ref_target(k, pc, imm, idx, rs, epc, cls, tgt, cause);
    if (r) begin
      m_pc = RST_PC; m_pend = 0; m_pend_eret = 0; m_exc = 0;
    end else if (m_exc) begin
      m_exc = 0;
      if (!st) m_pc = m_pc + 32'd4;
    end else if (v && b && cls == 3) begin
      m_pc = tgt; m_exc = 1; m_pend = 0;
      e.flush = 1'b1; e.req = 1'b1; e.cause = cause; e.epc = pc;
    end else if (m_pend) begin
      if (!st) begin
        m_pc = m_pend_tgt; m_pend = 0;
        e.flush = m_pend_eret; e.eret = m_pend_eret;
      end
    end else if (v && b && cls != 0) begin
      if (st) begin
        m_pend = 1; m_pend_tgt = tgt; m_pend_eret = (cls == 2);
      end else begin
        m_pc = tgt;
        e.flush = (cls == 2); e.eret = (cls == 2);
      end
    end else if (!st) begin
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc;
    sb_q.push_back(e);
  endtask

  task automatic idle(input bit st);
    step(0, st, 0, 0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn %0d %s got %h expected %h", txn, name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_out",    pc_out,            e.pc);
        chk("if_flush",  {31'd0, if_flush}, {31'd0, e.flush});
        chk("exc_req",   {31'd0, exc_req},  {31'd0, e.req});
        chk("exc_cause", {27'd0, exc_cause}, {27'd0, e.cause});
        chk("exc_epc",   exc_epc,           e.epc);
        chk("eret_ack",  {31'd0, eret_ack}, {31'd0, e.eret});
        $display("txn %0d pc=%h flush=%b req=%b cause=%0d epc=%h eret=%b",
                 txn, pc_out, if_flush, exc_req, exc_cause, exc_epc, eret_ack);
        txn++;
      end
    end
  end

  initial begin
    logic [31:0] r_pc, r_rs, r_epc;
    rst = 1'b1; if_stall = 1'b0; id_valid = 1'b0; id_branch = 1'b0;
    branch_ena = 4'd0; id_pc = '0; id_imm16 = '0; id_index26 = '0;
    rs_data = '0; epc_data = '0;
    m_pc = RST_PC; m_pend = 0; m_pend_eret = 0; m_exc = 0; m_pend_tgt = '0;

    // reset then sequential fetch
    step(1, 0, 0, 0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0);
    idle(0); idle(0);
    // BEQ backwards
    step(0, 0, 1, 1, 4'd3, 32'h0040_0010, 16'hFFFC, 26'd0, 32'd0, 32'd0);
    idle(0);
    // JR under stall, J during stall ignored
    step(0, 1, 1, 1, 4'd0, 32'h0040_0008, 16'd0, 26'd0, 32'h0040_1000, 32'd0);
    step(0, 1, 1, 1, 4'd1, 32'h0040_000C, 16'd0, 26'h0000_123, 32'd0, 32'd0);
    idle(1);
    idle(0);
    idle(0);
    // SYSCALL entry and deassert
    step(0, 0, 1, 1, 4'd8, 32'h0040_0020, 16'd0, 26'd0, 32'd0, 32'd0);
    idle(0); idle(0);
    // ERET direct, then ERET under stall interrupted by reset
    step(0, 0, 1, 1, 4'd9, 32'h0040_0030, 16'd0, 26'd0, 32'd0, 32'h0040_0024);
    idle(0);
    step(0, 1, 1, 1, 4'd9, 32'h0040_0030, 16'd0, 26'd0, 32'd0, 32'h0040_0080);
    step(1, 1, 0, 0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0);
    idle(0);
    // misaligned JR
    step(0, 0, 1, 1, 4'd0, 32'h0040_0008, 16'd0, 26'd0, 32'h0040_1002, 32'd0);
    idle(0); idle(0);
    // BNE parked, then BREAK overrides it during the stall
    step(0, 1, 1, 1, 4'd4, 32'h0040_0100, 16'h0010, 26'd0, 32'd0, 32'd0);
    step(0, 1, 1, 1, 4'd7, 32'h0040_0104, 16'd0, 26'd0, 32'd0, 32'd0);
    idle(1); idle(0);
    // TEQ under stall, unused kind 12
    step(0, 1, 1, 1, 4'd10, 32'h0040_0200, 16'd0, 26'd0, 32'd0, 32'd0);
    idle(0);
    step(0, 0, 1, 1, 4'd12, 32'h0040_0204, 16'd0, 26'd0, 32'h0040_5000, 32'd0);
    // JAL near a 256MB boundary
    step(0, 0, 1, 1, 4'd2, 32'h1FFF_FFFC, 16'd0, 26'h3FF_FFFF, 32'd0, 32'd0);
    idle(0);

    for (int i = 0; i < 700; i++) begin
      r_pc  = $urandom() & 32'hFFFF_FFFC;
      r_rs  = $urandom();
      r_epc = $urandom();
      if ($urandom_range(0, 3) != 0) r_rs  = r_rs  & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) != 0) r_epc = r_epc & 32'hFFFF_FFFC;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), r_pc, 16'($urandom()), 26'($urandom()),
           r_rs, r_epc);
    end

    idle(0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_sequencer.md
Name: branch_redirect_sequencer

Overview:
- Owns the fetch PC register of the static pipeline.
- Consumes the ID-stage branch decision and the 4-bit branch_ena kind code, then computes the redirect target.
- Handles instruction-fetch stalls by latching a pending redirect.
- Sequences exception entry (SYSCALL/BREAK/TEQ) and ERET return, driving IF flush and CP0 exception request.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0040_0004, exception entry address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_stall  in  1  instruction memory not ready; PC must hold
- id_valid  in  1  ID holds a valid instruction this cycle
- id_branch  in  1  branch/jump/trap taken decision from ID
- branch_ena  in  4  kind code: 0 JR, 1 J, 2 JAL, 3 BEQ, 4 BNE, 5 BGEZ, 6 JALR, 7 BREAK, 8 SYSCALL, 9 ERET, 10 TEQ
- id_pc  in  32  PC of the ID instruction
- id_imm16  in  16  branch offset field
- id_index26  in  26  jump index field
- rs_data  in  32  forwarded rs value
- epc_data  in  32  CP0 EPC
- pc_out  out  32  fetch PC (registered)
- if_flush  out  1  kill the instruction currently in IF
- exc_req  out  1  one-cycle exception request to CP0
- exc_cause  out  5  ExcCode: 8 Sys, 9 Bp, 13 Tr, 4 AdEL
- exc_epc  out  32  EPC to write (= id_pc)
- eret_ack  out  1  one-cycle pulse when the ERET redirect is applied

Behaviour:
- Reset (sync, rst=1 at posedge): pc_out=RESET_PC; if_flush=0; exc_req=0; exc_cause=0; exc_epc=0; eret_ack=0; state=RUN; pending cleared. rst overrides all inputs, including in PEND/EXC.
- Targets:
  - JR/JALR: rs_data.
  - J/JAL: {id_pc+4 [31:28], id_index26, 2'b00}.
  - BEQ/BNE/BGEZ: id_pc+4 + (sext(id_imm16)<<2), 32-bit wrap-around.
  - BREAK/SYSCALL/TEQ: EXC_VECTOR.
  - ERET: epc_data.
- A redirect event is id_valid & id_branch. Kinds 11–15 never redirect.
- States: RUN, PEND, EXC.
- RUN, no event:
  - if_stall=0: pc_out <= pc_out+4.
  - if_stall=1: hold.
- RUN, branch/jump event:
  - if_stall=0: pc_out <= target at the next edge; latency is 1 cycle. The delay slot already in IF is not flushed.
  - if_stall=1: latch target and kind; go to PEND.
- RUN, trap event (7/8/10): go to EXC regardless of if_stall.
  - pc_out <= EXC_VECTOR.
  - exc_req=1 and if_flush=1 for exactly one cycle.
  - exc_cause = 9/8/13; exc_epc = id_pc.
- RUN, ERET event:
  - pc_out <= epc_data; if_flush=1 for one cycle (no delay slot); eret_ack=1 for one cycle.
  - If if_stall=1: latch instead and apply on release.
- PEND:
  - pc_out holds while if_stall=1.
  - First cycle with if_stall=0: pc_out <= latched target; any ERET side-pulses fire; return to RUN.
  - A new branch/jump event in PEND is ignored; the older target is retained.
  - A trap event in PEND overrides the pending redirect and goes to EXC.
- EXC: lasts one cycle; outputs deassert; return to RUN. Events during EXC are ignored because ID is being flushed.
- Priority in any state: rst > trap > ERET > branch/jump > sequential +4.
- if_flush, exc_req and eret_ack are registered single-cycle pulses.

Optional Feature:
- ALIGN_CHECK_EN defined:
  - Any redirect target with target[1:0]!=0 (JR/JALR, ERET) raises an exception instead of redirecting.
  - exc_cause=4, exc_epc=id_pc, pc_out <= EXC_VECTOR, via EXC.
- ALIGN_CHECK_EN undefined: target[1:0] is forced to 2'b00 and no exception is raised.

Decomposition:
- Shared package:
  - branch_ena kind encodings (0–10).
  - ExcCode constants (4, 8, 9, 13).
  - RESET_PC and EXC_VECTOR defaults.
  - State encodings (RUN, PEND, EXC).
- One natural sub-module, redirect_target_calc: purely combinational target/kind/misalign computation. The sequencer keeps the FSM, PC and pending registers.

Test Plan:
- Reset then 3 cycles, no stall -> pc_out 0x00400000, 0x00400004, 0x00400008; all pulses 0.
- BEQ taken, id_pc=0x00400010, imm=0xFFFC, if_stall=0 -> next pc_out=0x00400004; if_flush=0.
- JR with rs=0x00401000 while if_stall=1 for 3 cycles -> pc_out holds; on release, pc_out=0x00401000; a second J during the stall is ignored.
- SYSCALL at id_pc=0x00400020 -> next cycle pc_out=0x00400004, exc_req=1, exc_cause=8, exc_epc=0x00400020, if_flush=1; all 0 the cycle after.
- ERET with epc=0x00400024 -> pc_out=0x00400024, if_flush=1, eret_ack=1 for one cycle; rst asserted in PEND -> pc_out=RESET_PC.
- ALIGN_CHECK_EN: JR rs=0x00401002 -> exc_cause=4, pc_out=0x00400004. Macro off: pc_out=0x00401000.
